// File: rtl/inst_mem_pkg.sv
// Shared definitions for the synchronous instruction memory: fault codes,
// the default NOP word and the legal read-latency range.
package inst_mem_pkg;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  function automatic bit lat_legal(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// 1W/1R word RAM with a registered read port, written to map onto block RAM.
// The read register has a synchronous clear so the fetch output starts at zero.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          INST_W    = 32,
  parameter logic [INST_W-1:0] INIT_WORD = INST_W'(NOP_INST_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [INST_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [INST_W-1:0]        rd_data
);

  // Initial contents are a simulation/bitstream image only; reset never clears them.
  logic [INST_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its word until the next read
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory for the fetch stage: req/ready fetch with
// fault decode, 1- or 2-cycle read pipeline, and a program-load write port.
module inst_mem_sync
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int INST_W   = 32,
  parameter int DEPTH    = 2 ** (ADDR_W - 2),
  parameter int READ_LAT = 1,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [INST_W-1:0]        fetch_inst,
  output logic [1:0]               fetch_fault,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [INST_W-1:0]        load_data
);

  localparam int LA_W = $clog2(DEPTH);
  localparam int WI_W = ADDR_W - 2;
  localparam logic [WI_W:0] DEPTH_WI = (WI_W + 1)'(DEPTH);
  localparam logic [LA_W:0] DEPTH_LA = (LA_W + 1)'(DEPTH);

  if (!lat_legal(READ_LAT)) begin : g_bad_lat
    $error("inst_mem_sync: READ_LAT must be 1 or 2");
  end
  if (DEPTH > 2 ** (ADDR_W - 2)) begin : g_bad_depth
    $error("inst_mem_sync: DEPTH exceeds the fetch address space");
  end

  logic [WI_W-1:0]   word_idx;
  logic [1:0]        fault_s;
  logic              accept_s;
  logic              rd_en_s;
  logic              wr_en_s;
  logic [INST_W-1:0] rdata_s;
  logic [INST_W-1:0] stage1_inst_s;
  logic              v1_r;
  logic [1:0]        f1_r;

  assign word_idx = fetch_addr[ADDR_W-1:2];

  // Fault decode: misalignment outranks range
  always_comb begin
    fault_s = FAULT_NONE;
    if (fetch_addr[1:0] != 2'b00) begin
      fault_s = FAULT_MISALIGN;
    end else if ({1'b0, word_idx} >= DEPTH_WI) begin
      fault_s = FAULT_RANGE;
    end else begin
      fault_s = FAULT_NONE;
    end
  end

  // A load owns the cycle, so reads and writes never meet at the array
  assign fetch_ready = !reset && !load_en;
  assign accept_s    = fetch_req && fetch_ready;
  assign rd_en_s     = accept_s && (fault_s == FAULT_NONE);
  assign wr_en_s     = load_en && !reset && ({1'b0, load_addr} < DEPTH_LA);

  inst_mem_array #(
    .DEPTH     (DEPTH),
    .INST_W    (INST_W),
    .INIT_WORD (NOP_INST)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (rd_en_s),
    .rd_addr (word_idx[LA_W-1:0]),
    .rd_data (rdata_s)
  );

  // Stage 1: valid bit and fault code travelling alongside the array read
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_r <= 1'b0;
      f1_r <= FAULT_NONE;
    end else begin
      v1_r <= accept_s;
      if (accept_s) begin
        f1_r <= fault_s;
      end
    end
  end

  assign stage1_inst_s = (f1_r == FAULT_NONE) ? rdata_s : NOP_INST;

  if (READ_LAT == 1) begin : g_lat1
    assign fetch_valid = v1_r;
    assign fetch_inst  = stage1_inst_s;
    assign fetch_fault = f1_r;
  end else begin : g_lat2
    logic              v2_r;
    logic [INST_W-1:0] inst2_r;
    logic [1:0]        f2_r;

    // Stage 2 output register; captures only on a live stage-1 response
    always_ff @(posedge clk) begin
      if (reset) begin
        v2_r    <= 1'b0;
        inst2_r <= '0;
        f2_r    <= FAULT_NONE;
      end else begin
        v2_r <= v1_r;
        if (v1_r) begin
          inst2_r <= stage1_inst_s;
          f2_r    <= f1_r;
        end
      end
    end

    assign fetch_valid = v2_r;
    assign fetch_inst  = inst2_r;
    assign fetch_fault = f2_r;
  end

endmodule
